wta_pwm_core: RTL
=================

// Module: wta_pwm_core
// PURPOSE
//  Parametrised winner-take-all core for the tt_um_wta_pwm top. It measures the
//  high time of N_CH PWM inputs over a fixed frame, then scans the snapshots
//  sequentially to pick the winner. It reports the winner index and count,
//  tie/none flags, and a registered copy of the winning PWM stream.
//  Adds over the first generation: any channel count and width, a tie-break
//  mode (hysteresis), and a minimum-count threshold.
// PARAMETERS
//  N_CH      8    number of PWM input channels (>=2)
//  CNT_W     8    width of the high-time accumulators (saturating)
//  FRAME_LEN 256  frame length in enabled clk cycles (>= N_CH+2)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  ena          in   1       design enable; low freezes frame counter and accumulators
//  pwm_in       in   N_CH    PWM inputs, already synchronised upstream
//  min_cnt      in   CNT_W   threshold; a best count below it gives no winner
//  tie_mode     in   1       0: lowest index wins ties; 1: previous winner keeps ties
//  winner_idx   out  IDX_W   index of the last valid winner (IDX_W=$clog2(N_CH))
//  winner_cnt   out  CNT_W   high-time count of the best channel, last frame
//  winner_none  out  1       best < min_cnt in the last frame
//  tie          out  1       more than one channel equals the best count
//  result_valid out  1       1-cycle pulse when the outputs above update
//  frame_tick   out  1       1-cycle pulse on the last cycle of each frame
//  busy         out  1       scan in progress
//  pwm_out      out  1       registered pwm_in[winner_idx]; 0 while winner_none
// BEHAVIOUR
//  Reset: all outputs, accumulators, snapshots and the frame counter go to 0.
//   The FSM goes to IDLE. An async assert mid-scan aborts the scan; no result.
//  Frame counter: runs 0..FRAME_LEN-1, advancing only when ena=1.
//  Accumulators: when ena=1, acc[i] += pwm_in[i]. Saturates at 2^CNT_W-1.
//  Frame end (frame_cnt==FRAME_LEN-1 and ena, cycle E):
//   - frame_tick=1.
//   - snap[i] <= sat(acc[i]+pwm_in[i]).
//   - acc[i] <= 0 and frame_cnt <= 0; the next frame starts at E+1 with no gap.
//  FSM: IDLE -> SCAN -> DONE -> IDLE.
//   - IDLE -> SCAN at frame end; load idx=0, best=0, bidx=0, tie_r=0.
//   - SCAN, one channel per cycle (E+1..E+N_CH):
//     - snap[idx] > best: best/bidx update, tie_r cleared.
//     - snap[idx] == best and idx>0: tie_r set. If tie_mode=1 and
//       idx==winner_idx, bidx <= idx.
//     - idx==N_CH-1 -> DONE.
//   - DONE (E+N_CH+1): result_valid=1, winner_cnt<=best, tie<=tie_r.
//     - best < min_cnt: winner_none<=1, winner_idx held.
//     - otherwise: winner_none<=0, winner_idx<=bidx.
//     - Then -> IDLE.
//   - Latency: frame end to result_valid is N_CH+1 cycles.
//   - busy=1 in SCAN and DONE.
//  All-zero frame: best=0, tie=1. winner_none=1 if min_cnt>0; else idx 0 wins.
//  ena low during a scan: the scan still completes (depends only on snap).
//  The FRAME_LEN>=N_CH+2 guarantee means a new frame end never hits SCAN;
//   an elaboration assertion checks it.
//  pwm_out: registered every cycle as pwm_in[winner_idx] & ~winner_none.
//   It switches source on the cycle after result_valid.
// STRUCTURE
//  wta_pwm_pkg:
//   - state enum {IDLE,SCAN,DONE};
//   - sat_inc function (saturating add);
//   - IDX_W derivation helper.
//  Sub-module wta_pwm_acc: one saturating accumulator plus snapshot register
//   per channel, generated N_CH times. Scan FSM and compare stay in the core.
// TESTING
//  - N_CH=4, FRAME_LEN=16:
//    - duty 2/5/9/3 -> result_valid at E+5, idx=2, cnt=9, tie=0, none=0.
//    - ch1 and ch3 both 7 high, tie_mode=0 -> idx=1, tie=1. Then previous
//      winner=3, tie_mode=1 -> idx=3.
//    - all channels <3 with min_cnt=3 -> winner_none=1, idx held, pwm_out=0.
//  - CNT_W=4, FRAME_LEN=32, ch0 high all frame -> cnt saturates at 15, no wrap.
//  - ena low for 5 cycles mid-frame -> frame_tick delayed by exactly 5 cycles,
//    counts unchanged.
//  - rst_n low during SCAN -> outputs 0, no result_valid; next frame scores normally.

Source files
------------

// File: rtl/wta_pwm_pkg.sv
// Shared types and helpers for the winner-take-all PWM core.
package wta_pwm_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam int SAT_MAX_W = 32;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Increment a w-bit counter (carried in a 32-bit container), stick at all-ones.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] a,
                                                   input logic inc, input int w);
    logic [SAT_MAX_W-1:0] max;
    max = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    return (inc && (a < max)) ? a + SAT_MAX_W'(1) : a;
  endfunction

endpackage

// File: rtl/wta_pwm_acc.sv
// One channel: saturating high-time accumulator and its end-of-frame snapshot.
module wta_pwm_acc
  import wta_pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ena,
  input  logic             i_pwm,
  input  logic             i_frame_end,
  output logic [CNT_W-1:0] o_snap
);

  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_snap;
  logic [CNT_W-1:0] w_sum;

  // The last cycle of the frame still counts, so the snapshot takes acc+pwm.
  assign w_sum  = CNT_W'(sat_inc(SAT_MAX_W'(r_acc), i_pwm, CNT_W));
  assign o_snap = r_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_snap <= '0;
    end else if (i_ena) begin
      if (i_frame_end) begin
        r_snap <= w_sum;
        r_acc  <= '0;
      end else begin
        r_acc  <= w_sum;
      end
    end
  end

endmodule

// File: rtl/wta_pwm_core.sv
// Winner-take-all over N_CH PWM inputs: per-frame high-time measurement,
// sequential scan of the snapshots, registered winner report and PWM mux.
module wta_pwm_core
  import wta_pwm_pkg::*;
#(
  parameter  int N_CH      = 8,
  parameter  int CNT_W     = 8,
  parameter  int FRAME_LEN = 256,
  localparam int IDX_W     = idx_w(N_CH),
  localparam int FC_W      = idx_w(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ena,
  input  logic [N_CH-1:0]  i_pwm_in,
  input  logic [CNT_W-1:0] i_min_cnt,
  input  logic             i_tie_mode,
  output logic [IDX_W-1:0] o_winner_idx,
  output logic [CNT_W-1:0] o_winner_cnt,
  output logic             o_winner_none,
  output logic             o_tie,
  output logic             o_result_valid,
  output logic             o_frame_tick,
  output logic             o_busy,
  output logic             o_pwm_out
);

  // A frame end must never land while a scan is still running.
  if (N_CH < 2 || FRAME_LEN < N_CH + 2 || CNT_W > SAT_MAX_W) begin : g_bad_cfg
    $error("wta_pwm_core: invalid parameter set");
  end

  logic [FC_W-1:0]             r_frame_cnt;
  logic                        w_frame_end;
  logic [N_CH-1:0][CNT_W-1:0]  w_snap;
  logic [CNT_W-1:0]            w_cur;

  state_e                      r_state, w_state_nxt;
  logic [IDX_W-1:0]            r_idx, r_bidx;
  logic [CNT_W-1:0]            r_best;
  logic                        r_tie_scan;

  logic [IDX_W-1:0]            r_winner_idx;
  logic [CNT_W-1:0]            r_winner_cnt;
  logic                        r_winner_none;
  logic                        r_tie;
  logic                        r_pwm_out;

  assign w_frame_end = i_ena && (r_frame_cnt == FC_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_frame_cnt <= '0;
    else if (w_frame_end) r_frame_cnt <= '0;
    else if (i_ena)       r_frame_cnt <= r_frame_cnt + FC_W'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    wta_pwm_acc #(.CNT_W(CNT_W)) u_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_ena       (i_ena),
      .i_pwm       (i_pwm_in[g]),
      .i_frame_end (w_frame_end),
      .o_snap      (w_snap[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_frame_end) w_state_nxt = SCAN;
      SCAN:    if (r_idx == IDX_W'(N_CH - 1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cur = w_snap[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_bidx     <= '0;
      r_best     <= '0;
      r_tie_scan <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_frame_end) begin
        r_idx      <= '0;
        r_bidx     <= '0;
        r_best     <= '0;
        r_tie_scan <= 1'b0;
      end
    end else if (r_state == SCAN) begin
      if (w_cur > r_best) begin
        r_best     <= w_cur;
        r_bidx     <= r_idx;
        r_tie_scan <= 1'b0;
      end else if (w_cur == r_best && r_idx != '0) begin
        r_tie_scan <= 1'b1;
        // Hysteresis: the standing winner keeps a tie instead of the lowest index.
        if (i_tie_mode && r_idx == r_winner_idx) r_bidx <= r_idx;
      end
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winner_idx  <= '0;
      r_winner_cnt  <= '0;
      r_winner_none <= 1'b0;
      r_tie         <= 1'b0;
      r_pwm_out     <= 1'b0;
    end else begin
      if (r_state == DONE) begin
        r_winner_cnt <= r_best;
        r_tie        <= r_tie_scan;
        if (r_best < i_min_cnt) begin
          r_winner_none <= 1'b1;
        end else begin
          r_winner_none <= 1'b0;
          r_winner_idx  <= r_bidx;
        end
      end
      r_pwm_out <= i_pwm_in[r_winner_idx] & ~r_winner_none;
    end
  end

  assign o_winner_idx   = r_winner_idx;
  assign o_winner_cnt   = r_winner_cnt;
  assign o_winner_none  = r_winner_none;
  assign o_tie          = r_tie;
  assign o_pwm_out      = r_pwm_out;
  assign o_result_valid = (r_state == DONE);
  assign o_busy         = (r_state != IDLE);
  assign o_frame_tick   = w_frame_end;

endmodule
